// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, rcon table, GF(2^8) helpers and the round-count function.
package aes_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StDone} aes_state_e;

    function automatic int unsigned aes_nr(input int unsigned key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32 * c -: 32] = mix_column(s[127 - 32 * c -: 32]);
        end
        return r;
    endfunction

    // Byte (row, col) lives at index row + 4*col, byte 0 in the MSBs.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_lo;

    assign bit_lo = 11'd2040 - {data_i, 3'b000};
    assign data_o = SBOX[bit_lo +: 8];

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: one round per clock with on-the-fly key expansion.
// Defining AES_ITER_BLOCK_CNT_EN adds a 32-bit completed-transfer counter output blk_cnt.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_block,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block
`ifdef AES_ITER_BLOCK_CNT_EN
    ,
    output logic [31:0]         blk_cnt
`endif
);

    localparam int unsigned NR = aes_nr(KEY_BITS);
    localparam logic [3:0] LastRnd = 4'(NR);

    aes_state_e          state_q, state_d;
    logic [3:0]          rnd_q, rnd_d, rcon_idx;
    logic [127:0]        s_q, s_d, out_block_q, out_block_d;
    logic [KEY_BITS-1:0] key_q, key_d, key_step;
    logic                out_valid_q, out_valid_d, rot_step;
    logic [127:0]        sub_bytes, shifted, round_out, round_key, new_words;
    logic [31:0]         key_sbox_in, key_sbox_out, key_temp, w0, w1, w2, w3;

    for (genvar i = 0; i < 16; i++) begin : gen_state_sbox
        aes_sbox u_sbox (.data_i(s_q[127 - 8 * i -: 8]), .data_o(sub_bytes[127 - 8 * i -: 8]));
    end

    // One word of S-boxes serves both the RotWord+SubWord and SubWord-only key steps.
    assign rot_step    = (KEY_BITS == 128) || rnd_q[0];
    assign key_sbox_in = rot_step ? {key_q[23:0], key_q[31:24]} : key_q[31:0];
    for (genvar i = 0; i < 4; i++) begin : gen_key_sbox
        aes_sbox u_sbox (.data_i(key_sbox_in[31 - 8 * i -: 8]),
                         .data_o(key_sbox_out[31 - 8 * i -: 8]));
    end

    assign rcon_idx  = (KEY_BITS == 128) ? rnd_q - 4'd1 : (rnd_q - 4'd1) >> 1;
    assign key_temp  = key_sbox_out ^ (rot_step ? {aes_rcon(rcon_idx), 24'h000000} : 32'h0);
    assign w0        = key_q[KEY_BITS-1 -: 32] ^ key_temp;
    assign w1        = key_q[KEY_BITS-33 -: 32] ^ w0;
    assign w2        = key_q[KEY_BITS-65 -: 32] ^ w1;
    assign w3        = key_q[KEY_BITS-97 -: 32] ^ w2;
    assign new_words = {w0, w1, w2, w3};

    // AES-256 keeps a two-round-key window; the round uses the younger half.
    if (KEY_BITS == 128) begin : gen_key128
        assign round_key = new_words;
        assign key_step  = new_words;
    end else if (KEY_BITS == 256) begin : gen_key256
        assign round_key = key_q[127:0];
        assign key_step  = {key_q[127:0], new_words};
    end else begin : gen_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    assign shifted   = shift_rows(sub_bytes);
    assign round_out = ((rnd_q == LastRnd) ? shifted : mix_columns(shifted)) ^ round_key;
    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        s_d         = s_q;
        key_d       = key_q;
        out_valid_d = out_valid_q;
        out_block_d = out_block_q;
        case (state_q)
            StRound: begin
                s_d   = round_out;
                key_d = key_step;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LastRnd) begin
                    state_d     = StDone;
                    rnd_d       = 4'd0;
                    out_valid_d = 1'b1;
                    out_block_d = round_out;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: ;
        endcase
        if (in_valid && in_ready) begin
            state_d = StRound;
            rnd_d   = 4'd1;
            s_d     = in_block ^ in_key[KEY_BITS-1 -: 128];
            key_d   = in_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rnd_q       <= '0;
            s_q         <= '0;
            key_q       <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            s_q         <= s_d;
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            out_block_q <= out_block_d;
        end
    end

`ifdef AES_ITER_BLOCK_CNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (out_valid_q && out_ready) blk_cnt_d = blk_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) blk_cnt_q <= '0;
        else     blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule
